battle_action: RTL and testbench
================================

BATTLE_ACTION -- requirements
Module: battle_action

Interface
REQ-001 Parameter: HP_MAX, default 100, starting and ceiling HP for player and enemy.
REQ-002 Parameter: MP_MAX, default 50, starting and ceiling player MP.
REQ-003 Parameter: HEAL_AMT, default 20, HP restored by heal; costs HEAL_COST, default 10, MP.
REQ-004 Parameter: MAGIC_AMT, default 15, MP restored by magic.
REQ-005 Parameter: ATK_DMG1..ATK_DMG4, defaults 5/10/15/20, enemy HP removed by attacks 1..4; ATK_COST1..ATK_COST4, defaults 0/0/5/10, MP cost.
REQ-006 Parameter: ENEMY_DMG, default 8, player HP removed per enemy turn.
REQ-007 Parameter: ANIM_CYCLES, default 16, length of each animation phase in cycles.
REQ-008 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-009 Port rst, input, 1, synchronous active-high reset.
REQ-010 Port command, input, 6, menu command: bit0..bit3 attack 1..4, bit4 heal, bit5 magic; held while the enter key is held.
REQ-011 Port player_hp, output, 7, player HP.
REQ-012 Port player_mp, output, 6, player MP.
REQ-013 Port enemy_hp, output, 7, enemy HP.
REQ-014 Port busy, output, 1, high whenever the state is not IDLE.
REQ-015 Port anim_id, output, 3, animation selector: 0 none, 1 heal, 2 magic, 3..6 attack 1..4, 7 enemy attack.
REQ-016 Port reject, output, 1, one-cycle pulse when a command is refused.
REQ-017 Port game_over, output, 1, high in OVER.
REQ-018 Port player_won, output, 1, valid while game_over is high: 1 means the enemy reached 0 HP.

Function
REQ-019 The FSM SHALL have the states IDLE, P_ACT, P_ANIM, E_ACT, E_ANIM and OVER.
REQ-020 An internal armed flag SHALL clear on every accept or reject and SHALL set on any cycle with command == 0.
REQ-021 In IDLE with armed=1 and command != 0, the block SHALL do exactly one of the following:
- accept and go to P_ACT, if command is one-hot and the MP cost is <= player_mp;
- otherwise pulse reject, stay in IDLE and change no register.
REQ-022 The command SHALL be ignored outside IDLE, and a held command SHALL never be accepted twice.
REQ-023 P_ACT SHALL last one cycle and update the registers at its end, so results are visible two cycles after the accept edge:
- heal: player_hp = min(hp+HEAL_AMT, HP_MAX), mp -= HEAL_COST;
- magic: mp = min(mp+MAGIC_AMT, MP_MAX);
- attack n: enemy_hp = max(enemy_hp-ATK_DMGn, 0), mp -= ATK_COSTn.
REQ-024 All arithmetic SHALL saturate, with no wrap-around, using intermediates one bit wider than the operand.
REQ-025 P_ANIM SHALL last exactly ANIM_CYCLES cycles with anim_id set to the action's code; anim_id SHALL be 0 in IDLE and OVER.
REQ-026 When P_ANIM ends, the FSM SHALL go to OVER with player_won=1 if enemy_hp==0, else to E_ACT.
REQ-027 E_ACT SHALL last one cycle and set player_hp = max(player_hp-ENEMY_DMG, 0).
REQ-028 E_ANIM SHALL last ANIM_CYCLES cycles with anim_id=7.
REQ-029 When E_ANIM ends, the FSM SHALL go to OVER with player_won=0 if player_hp==0, else to IDLE.
REQ-030 OVER SHALL hold all outputs and ignore commands until rst.
REQ-031 The animation counter SHALL be loaded on entry to P_ANIM/E_ANIM and count down to 0.

Reset
REQ-032 On rst, state SHALL become IDLE, player_hp=enemy_hp=HP_MAX, player_mp=MP_MAX, armed=0, anim counter=0, and anim_id, reject, game_over, player_won and busy SHALL be 0.
REQ-033 rst SHALL take priority in every state, including mid-animation and OVER.

Configuration
REQ-034 With ENEMY_TURN_EN defined, the enemy turn SHALL run as in REQ-026 to REQ-029.
REQ-035 Without ENEMY_TURN_EN, P_ANIM SHALL end in IDLE, or in OVER if enemy_hp==0; E_ACT/E_ANIM SHALL not exist, player_hp SHALL change only by heal, and anim_id SHALL never be 7.

Verification
REQ-036 Reset, command=000001 held 5 cycles -> enemy_hp 95 two cycles after accept; busy high; anim_id=3 for 16 cycles; one accept only.
REQ-037 After an enemy turn (player_hp 92), apply heal -> player_hp 100 (clamped), mp 40; with ENEMY_TURN_EN the result then becomes 92.
REQ-038 mp=0 state, command=001000 -> reject pulse 1 cycle, no register change, busy stays 0.
REQ-039 command=000011 (not one-hot) -> reject; release to 0, then 000010 -> accepted.
REQ-040 Drive enemy_hp to 15 and then use attack 4 -> enemy_hp 0 (saturated), OVER after P_ANIM, player_won=1, further commands ignored.
REQ-041 Assert rst during E_ANIM -> next cycle IDLE, HP 100/100, MP 50, anim_id 0.

Source files
------------

// File: rtl/battle_action.sv
// Turn-based battle engine: one player action per turn, optional enemy counter-turn.
// Optional feature macro: ENEMY_TURN_EN enables the E_ACT/E_ANIM enemy turn.
module battle_action #(
    parameter int HP_MAX      = 100,
    parameter int MP_MAX      = 50,
    parameter int HEAL_AMT    = 20,
    parameter int HEAL_COST   = 10,
    parameter int MAGIC_AMT   = 15,
    parameter int ATK_DMG1    = 5,
    parameter int ATK_DMG2    = 10,
    parameter int ATK_DMG3    = 15,
    parameter int ATK_DMG4    = 20,
    parameter int ATK_COST1   = 0,
    parameter int ATK_COST2   = 0,
    parameter int ATK_COST3   = 5,
    parameter int ATK_COST4   = 10,
    parameter int ENEMY_DMG   = 8,
    parameter int ANIM_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] command,
    output logic [6:0] player_hp,
    output logic [5:0] player_mp,
    output logic [6:0] enemy_hp,
    output logic       busy,
    output logic [2:0] anim_id,
    output logic       reject,
    output logic       game_over,
    output logic       player_won
);

    localparam int CW = (ANIM_CYCLES > 1) ? $clog2(ANIM_CYCLES) : 1;
    localparam logic [CW-1:0] ANIM_LOAD = CW'(ANIM_CYCLES - 1);

`ifdef ENEMY_TURN_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        P_ACT  = 3'd1,
        P_ANIM = 3'd2,
        E_ACT  = 3'd3,
        E_ANIM = 3'd4,
        OVER   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        P_ACT  = 3'd1,
        P_ANIM = 3'd2,
        OVER   = 3'd5
    } state_t;
`endif

    state_t          state_r, next_state_s;
    logic            armed_r;
    logic [2:0]      act_r;
    logic [CW-1:0]   cnt_r;
    logic [6:0]      player_hp_r, enemy_hp_r, php_nx_s, ehp_nx_s;
    logic [5:0]      player_mp_r, pmp_nx_s;
    logic            busy_r, reject_r, game_over_r, player_won_r;
    logic [2:0]      anim_r, anim_nx_s, cmd_code_s;
    logic            accept_s, reject_s;

    // Command code doubles as the animation code: 1 heal, 2 magic, 3..6 attack 1..4, 0 invalid.
    function automatic logic [2:0] decode_cmd(input logic [5:0] cmd);
        case (cmd)
            6'b000001: return 3'd3;
            6'b000010: return 3'd4;
            6'b000100: return 3'd5;
            6'b001000: return 3'd6;
            6'b010000: return 3'd1;
            6'b100000: return 3'd2;
            default:   return 3'd0;
        endcase
    endfunction

    function automatic logic [5:0] cost_of(input logic [2:0] code);
        case (code)
            3'd1:    return 6'(HEAL_COST);
            3'd3:    return 6'(ATK_COST1);
            3'd4:    return 6'(ATK_COST2);
            3'd5:    return 6'(ATK_COST3);
            3'd6:    return 6'(ATK_COST4);
            default: return 6'd0;
        endcase
    endfunction

    function automatic logic [6:0] dmg_of(input logic [2:0] code);
        case (code)
            3'd3:    return 7'(ATK_DMG1);
            3'd4:    return 7'(ATK_DMG2);
            3'd5:    return 7'(ATK_DMG3);
            3'd6:    return 7'(ATK_DMG4);
            default: return 7'd0;
        endcase
    endfunction

    function automatic logic [6:0] sat_add7(input logic [6:0] a, input logic [6:0] b,
                                            input logic [6:0] lim);
        logic [7:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[6:0];
    endfunction

    function automatic logic [6:0] sat_sub7(input logic [6:0] a, input logic [6:0] b);
        logic [7:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[7] ? 7'd0 : d[6:0];
    endfunction

    function automatic logic [5:0] sat_add6(input logic [5:0] a, input logic [5:0] b,
                                            input logic [5:0] lim);
        logic [6:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[5:0];
    endfunction

    function automatic logic [5:0] sat_sub6(input logic [5:0] a, input logic [5:0] b);
        logic [6:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[6] ? 6'd0 : d[5:0];
    endfunction

    function automatic logic [6:0] enemy_strike(input logic [6:0] hp);
        return sat_sub7(hp, 7'(ENEMY_DMG));
    endfunction

    // Next-state logic and accept/reject decision.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        reject_s     = 1'b0;
        cmd_code_s   = decode_cmd(command);
        case (state_r)
            IDLE: begin
                if (armed_r && (command != 6'd0)) begin
                    if ((cmd_code_s != 3'd0) && (cost_of(cmd_code_s) <= player_mp_r)) begin
                        accept_s     = 1'b1;
                        next_state_s = P_ACT;
                    end else begin
                        reject_s = 1'b1;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            P_ACT: next_state_s = P_ANIM;
            P_ANIM: begin
                if (cnt_r == '0) begin
`ifdef ENEMY_TURN_EN
                    next_state_s = (enemy_hp_r == 7'd0) ? OVER : E_ACT;
`else
                    next_state_s = (enemy_hp_r == 7'd0) ? OVER : IDLE;
`endif
                end else begin
                    next_state_s = P_ANIM;
                end
            end
`ifdef ENEMY_TURN_EN
            E_ACT: next_state_s = E_ANIM;
            E_ANIM: begin
                if (cnt_r == '0) begin
                    next_state_s = (player_hp_r == 7'd0) ? OVER : IDLE;
                end else begin
                    next_state_s = E_ANIM;
                end
            end
`endif
            OVER:    next_state_s = OVER;
            default: next_state_s = IDLE;
        endcase
    end

    // Stat updates: applied only at the end of the one-cycle action states.
    always_comb begin
        php_nx_s  = player_hp_r;
        pmp_nx_s  = player_mp_r;
        ehp_nx_s  = enemy_hp_r;
        if (state_r == P_ACT) begin
            case (act_r)
                3'd1: begin
                    php_nx_s = sat_add7(player_hp_r, 7'(HEAL_AMT), 7'(HP_MAX));
                    pmp_nx_s = sat_sub6(player_mp_r, 6'(HEAL_COST));
                end
                3'd2: pmp_nx_s = sat_add6(player_mp_r, 6'(MAGIC_AMT), 6'(MP_MAX));
                3'd3, 3'd4, 3'd5, 3'd6: begin
                    ehp_nx_s = sat_sub7(enemy_hp_r, dmg_of(act_r));
                    pmp_nx_s = sat_sub6(player_mp_r, cost_of(act_r));
                end
                default: ehp_nx_s = enemy_hp_r;
            endcase
        end
`ifdef ENEMY_TURN_EN
        else if (state_r == E_ACT) begin
            php_nx_s = enemy_strike(player_hp_r);
        end
`endif
        else begin
            php_nx_s = player_hp_r;
        end
    end

    // Animation selector follows the state being entered so the output register lines up.
    always_comb begin
        anim_nx_s = 3'd0;
        if (next_state_s == P_ANIM) begin
            anim_nx_s = act_r;
        end
`ifdef ENEMY_TURN_EN
        else if (next_state_s == E_ANIM) begin
            anim_nx_s = 3'd7;
        end
`endif
        else begin
            anim_nx_s = 3'd0;
        end
    end

    // State, stats, arming, animation counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            armed_r      <= 1'b0;
            act_r        <= 3'd0;
            cnt_r        <= '0;
            player_hp_r  <= 7'(HP_MAX);
            enemy_hp_r   <= 7'(HP_MAX);
            player_mp_r  <= 6'(MP_MAX);
            busy_r       <= 1'b0;
            anim_r       <= 3'd0;
            reject_r     <= 1'b0;
            game_over_r  <= 1'b0;
            player_won_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            player_hp_r <= php_nx_s;
            enemy_hp_r  <= ehp_nx_s;
            player_mp_r <= pmp_nx_s;
            if (accept_s || reject_s) begin
                armed_r <= 1'b0;
            end else if (command == 6'd0) begin
                armed_r <= 1'b1;
            end
            if (accept_s) begin
                act_r <= cmd_code_s;
            end
            if (state_r == P_ACT) begin
                cnt_r <= ANIM_LOAD;
            end
`ifdef ENEMY_TURN_EN
            else if (state_r == E_ACT) begin
                cnt_r <= ANIM_LOAD;
            end
`endif
            else if (cnt_r != '0) begin
                cnt_r <= cnt_r - 1'b1;
            end
            busy_r      <= (next_state_s != IDLE);
            anim_r      <= anim_nx_s;
            reject_r    <= reject_s;
            game_over_r <= (next_state_s == OVER);
            if ((next_state_s == OVER) && (state_r != OVER)) begin
                player_won_r <= (enemy_hp_r == 7'd0);
            end
        end
    end

    assign player_hp  = player_hp_r;
    assign player_mp  = player_mp_r;
    assign enemy_hp   = enemy_hp_r;
    assign busy       = busy_r;
    assign anim_id    = anim_r;
    assign reject     = reject_r;
    assign game_over  = game_over_r;
    assign player_won = player_won_r;

endmodule

// File: tb/tb_battle_action.sv
// Directed self-checking bench for battle_action (default parameters; ENEMY_TURN_EN-aware).
module tb_battle_action;

`ifdef ENEMY_TURN_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] command = 6'd0;
    logic [6:0] player_hp, enemy_hp;
    logic [5:0] player_mp;
    logic       busy, reject, game_over, player_won;
    logic [2:0] anim_id;

    int n_cmp = 0;
    int n_bad = 0;

    battle_action dut (
        .clk(clk), .rst(rst), .command(command),
        .player_hp(player_hp), .player_mp(player_mp), .enemy_hp(enemy_hp),
        .busy(busy), .anim_id(anim_id), .reject(reject),
        .game_over(game_over), .player_won(player_won)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Arm with one idle cycle, issue c for one cycle, then wait for the turn to finish.
    task automatic run_cmd(input logic [5:0] c);
        command = 6'd0;
        @(negedge clk);
        command = c;
        @(negedge clk);
        command = 6'd0;
        for (int i = 0; i < 200; i++) begin
            if (busy === 1'b0) break;
            @(negedge clk);
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL turn_end: busy %b expected 0", busy); end
    endtask

    task automatic test_reset;
        rst = 1'b1; command = 6'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (player_hp !== 7'd100) begin n_bad++; $display("FAIL rst_php: %0d expected 100", player_hp); end
        n_cmp++; if (enemy_hp !== 7'd100) begin n_bad++; $display("FAIL rst_ehp: %0d expected 100", enemy_hp); end
        n_cmp++; if (player_mp !== 6'd50) begin n_bad++; $display("FAIL rst_mp: %0d expected 50", player_mp); end
        n_cmp++; if ({busy, reject, game_over, player_won, anim_id} !== 7'd0) begin
            n_bad++; $display("FAIL rst_flags: %b expected 0", {busy, reject, game_over, player_won, anim_id});
        end
    endtask

    task automatic test_attack_held;
        int n3, n7, nrej;
        n3 = 0; n7 = 0; nrej = 0;
        command = 6'd0;
        @(negedge clk);
        command = 6'b000001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (anim_id === 3'd3) n3++;
            if (reject === 1'b1) nrej++;
            if (i == 0) begin
                n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL atk_busy: %b expected 1", busy); end
            end
            if (i == 1) begin
                n_cmp++; if (enemy_hp !== 7'd95) begin n_bad++; $display("FAIL atk_ehp: %0d expected 95", enemy_hp); end
            end
        end
        command = 6'd0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (anim_id === 3'd3) n3++;
            if (anim_id === 3'd7) n7++;
            if (reject === 1'b1) nrej++;
            if (busy === 1'b0) break;
        end
        n_cmp++; if (n3 != 16) begin n_bad++; $display("FAIL atk_anim3: %0d cycles expected 16", n3); end
        n_cmp++; if (n7 != (EN ? 16 : 0)) begin n_bad++; $display("FAIL atk_anim7: %0d cycles expected %0d", n7, EN ? 16 : 0); end
        n_cmp++; if (nrej != 0) begin n_bad++; $display("FAIL atk_reject: %0d pulses expected 0", nrej); end
        n_cmp++; if (enemy_hp !== 7'd95) begin n_bad++; $display("FAIL atk_once: %0d expected 95", enemy_hp); end
        n_cmp++; if (player_hp !== (EN ? 7'd92 : 7'd100)) begin n_bad++; $display("FAIL atk_php: %0d", player_hp); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL atk_idle: busy %b expected 0", busy); end
    endtask

    task automatic test_heal;
        command = 6'd0;
        @(negedge clk);
        command = 6'b010000;
        @(negedge clk);
        command = 6'd0;
        repeat (2) @(negedge clk);
        n_cmp++; if (player_hp !== 7'd100) begin n_bad++; $display("FAIL heal_clamp: %0d expected 100", player_hp); end
        n_cmp++; if (player_mp !== 6'd40) begin n_bad++; $display("FAIL heal_mp: %0d expected 40", player_mp); end
        n_cmp++; if (anim_id !== 3'd1) begin n_bad++; $display("FAIL heal_anim: %0d expected 1", anim_id); end
        run_cmd(6'd0);
        n_cmp++; if (player_hp !== (EN ? 7'd92 : 7'd100)) begin n_bad++; $display("FAIL heal_end: %0d", player_hp); end
    endtask

    task automatic test_magic;
        command = 6'd0;
        @(negedge clk);
        command = 6'b100000;
        @(negedge clk);
        command = 6'd0;
        repeat (2) @(negedge clk);
        n_cmp++; if (player_mp !== 6'd50) begin n_bad++; $display("FAIL magic_clamp: %0d expected 50", player_mp); end
        n_cmp++; if (anim_id !== 3'd2) begin n_bad++; $display("FAIL magic_anim: %0d expected 2", anim_id); end
        run_cmd(6'd0);
        n_cmp++; if (player_hp !== (EN ? 7'd84 : 7'd100)) begin n_bad++; $display("FAIL magic_php: %0d", player_hp); end
    endtask

    task automatic test_not_onehot;
        command = 6'd0;
        @(negedge clk);
        command = 6'b000011;
        @(negedge clk);
        n_cmp++; if (reject !== 1'b1) begin n_bad++; $display("FAIL mh_reject: %b expected 1", reject); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mh_busy: %b expected 0", busy); end
        @(negedge clk);
        n_cmp++; if (reject !== 1'b0) begin n_bad++; $display("FAIL mh_pulse: %b expected 0", reject); end
        run_cmd(6'b000010);
        n_cmp++; if (enemy_hp !== 7'd85) begin n_bad++; $display("FAIL mh_accept: %0d expected 85", enemy_hp); end
    endtask

    task automatic test_mp_boundary;
        for (int k = 0; k < 5; k++) run_cmd(6'b010000);
        n_cmp++; if (player_mp !== 6'd0) begin n_bad++; $display("FAIL mp_drain: %0d expected 0", player_mp); end
        n_cmp++; if (player_hp !== (EN ? 7'd92 : 7'd100)) begin n_bad++; $display("FAIL mp_php: %0d", player_hp); end
        command = 6'd0;
        @(negedge clk);
        command = 6'b001000;
        @(negedge clk);
        n_cmp++; if (reject !== 1'b1) begin n_bad++; $display("FAIL mp_reject: %b expected 1", reject); end
        @(negedge clk);
        command = 6'd0;
        n_cmp++; if (reject !== 1'b0) begin n_bad++; $display("FAIL mp_pulse: %b expected 0", reject); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mp_busy: %b expected 0", busy); end
        n_cmp++; if ({enemy_hp, player_mp} !== {7'd85, 6'd0}) begin
            n_bad++; $display("FAIL mp_regs: ehp %0d mp %0d expected 85 0", enemy_hp, player_mp);
        end
    endtask

    task automatic test_kill;
        int nrej;
        nrej = 0;
        for (int k = 0; k < 7; k++) run_cmd(6'b000010);
        n_cmp++; if (enemy_hp !== 7'd15) begin n_bad++; $display("FAIL kill_pre: %0d expected 15", enemy_hp); end
        run_cmd(6'b100000);
        n_cmp++; if (player_mp !== 6'd15) begin n_bad++; $display("FAIL kill_mp: %0d expected 15", player_mp); end
        command = 6'd0;
        @(negedge clk);
        command = 6'b001000;
        @(negedge clk);
        command = 6'd0;
        for (int i = 0; i < 200; i++) begin
            if (game_over === 1'b1) break;
            @(negedge clk);
        end
        n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL kill_over: %b expected 1", game_over); end
        n_cmp++; if (player_won !== 1'b1) begin n_bad++; $display("FAIL kill_won: %b expected 1", player_won); end
        n_cmp++; if (enemy_hp !== 7'd0) begin n_bad++; $display("FAIL kill_sat: %0d expected 0", enemy_hp); end
        n_cmp++; if (player_mp !== 6'd5) begin n_bad++; $display("FAIL kill_mpcost: %0d expected 5", player_mp); end
        n_cmp++; if (anim_id !== 3'd0) begin n_bad++; $display("FAIL kill_anim: %0d expected 0", anim_id); end
        @(negedge clk);
        command = 6'b100000;
        repeat (4) begin
            @(negedge clk);
            if (reject === 1'b1) nrej++;
        end
        command = 6'd0;
        n_cmp++; if (nrej != 0) begin n_bad++; $display("FAIL over_reject: %0d expected 0", nrej); end
        n_cmp++; if ({game_over, player_won, player_mp} !== {1'b1, 1'b1, 6'd5}) begin
            n_bad++; $display("FAIL over_hold: go %b won %b mp %0d expected 1 1 5", game_over, player_won, player_mp);
        end
        n_cmp++; if (player_hp !== (EN ? 7'd28 : 7'd100)) begin n_bad++; $display("FAIL over_php: %0d", player_hp); end
    endtask

    task automatic test_reset_mid_anim;
        rst = 1'b1; command = 6'd0;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL over_rst: %b expected 0", game_over); end
        @(negedge clk);
        command = 6'b000001;
        @(negedge clk);
        command = 6'd0;
        for (int i = 0; i < 200; i++) begin
            if (anim_id === (EN ? 3'd7 : 3'd3)) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        n_cmp++; if (anim_id !== (EN ? 3'd7 : 3'd3)) begin n_bad++; $display("FAIL mid_anim: %0d", anim_id); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if ({busy, anim_id, game_over, reject} !== 6'd0) begin
            n_bad++; $display("FAIL mid_rst_flags: %b expected 0", {busy, anim_id, game_over, reject});
        end
        n_cmp++; if ({player_hp, enemy_hp, player_mp} !== {7'd100, 7'd100, 6'd50}) begin
            n_bad++; $display("FAIL mid_rst_regs: %0d %0d %0d expected 100 100 50", player_hp, enemy_hp, player_mp);
        end
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_idle: %b expected 0", busy); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_attack_held;
        test_heal;
        test_magic;
        test_not_onehot;
        test_mp_boundary;
        test_kill;
        test_reset_mid_anim;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
